voice_allocator: RTL and testbench

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

---
 rtl/voice_allocator_pkg.sv | 23 ++
 rtl/voice_select.sv | 62 ++++++
 rtl/voice_allocator.sv | 78 +++++++
 tb/tb_voice_allocator.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/voice_allocator_pkg.sv
// voice_allocator_pkg: shared MIDI message and voice types
package MIDI;
  typedef enum logic [2:0] {
    NOTE_OFF,
    NOTE_ON,
    POLY_PRESSURE,
    CONTROL_CHANGE,
    PROGRAM_CHANGE,
    CHANNEL_PRESSURE,
    PITCH_BEND,
    SYSTEM
  } message_type_t;
  typedef struct packed {
    message_type_t message_type;
    logic [6:0]    data_byte1;
    logic [6:0]    data_byte2;
  } message_t;
endpackage

package VOICE;
  typedef enum logic [1:0] {IDLE, HELD, RELEASING} voice_state_t;
  localparam logic [6:0] ALL_NOTES_OFF = 7'd123;
endpackage

// File: rtl/voice_select.sv
// voice_select: combinational choice of matching, lowest idle and steal voices
module voice_select
  import VOICE::*;
#(
  parameter int NUM_VOICES = 4,
  localparam int RW = $clog2(NUM_VOICES)
) (
  input  voice_state_t  state [NUM_VOICES],
  input  logic [6:0]    note  [NUM_VOICES],
  input  logic [RW-1:0] rank  [NUM_VOICES],
  input  logic [6:0]    key,
  output logic          match_valid,
  output logic [RW-1:0] match_index,
  output logic          held_valid,
  output logic [RW-1:0] held_index,
  output logic          idle_valid,
  output logic [RW-1:0] idle_index,
  output logic [RW-1:0] steal_index
);
  logic          rel_valid, old_valid;
  logic [RW-1:0] rel_index, rel_rank, old_index, old_rank;
  // downward scan lets the lowest index win the searches; oldest is the highest rank
  always_comb begin
    match_valid = 1'b0;
    match_index = '0;
    held_valid  = 1'b0;
    held_index  = '0;
    idle_valid  = 1'b0;
    idle_index  = '0;
    rel_valid   = 1'b0;
    rel_index   = '0;
    rel_rank    = '0;
    old_valid   = 1'b0;
    old_index   = '0;
    old_rank    = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (state[i] != IDLE && note[i] == key) begin
        match_valid = 1'b1;
        match_index = RW'(i);
      end
      if (state[i] == HELD && note[i] == key) begin
        held_valid = 1'b1;
        held_index = RW'(i);
      end
      if (state[i] == IDLE) begin
        idle_valid = 1'b1;
        idle_index = RW'(i);
      end
      if (state[i] == RELEASING && (!rel_valid || rank[i] > rel_rank)) begin
        rel_valid = 1'b1;
        rel_index = RW'(i);
        rel_rank  = rank[i];
      end
      if (state[i] == HELD && (!old_valid || rank[i] > old_rank)) begin
        old_valid = 1'b1;
        old_index = RW'(i);
        old_rank  = rank[i];
      end
    end
    steal_index = rel_valid ? rel_index : old_index;
  end
endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic voice allocation with retrigger and age-based stealing
module voice_allocator
  import MIDI::*, VOICE::*;
#(
  parameter int NUM_VOICES = 4
) (
  input  logic                  clock_50_000_000,
  input  logic                  reset,
  input  message_t              message,
  input  logic                  message_ready,
  input  logic [NUM_VOICES-1:0] release_done,
  output voice_state_t          voice_state    [NUM_VOICES],
  output logic [6:0]            voice_note     [NUM_VOICES],
  output logic [6:0]            voice_velocity [NUM_VOICES],
  output logic [NUM_VOICES-1:0] voice_gate_on,
  output logic [NUM_VOICES-1:0] voice_gate_off
);
  localparam int RW = $clog2(NUM_VOICES);
  logic [RW-1:0]         rank [NUM_VOICES];
  logic                  note_on, note_off, all_off, match_valid, held_valid, idle_valid;
  logic [RW-1:0]         match_index, held_index, idle_index, steal_index, target;
  logic [NUM_VOICES-1:0] gate_on, gate_off;
  voice_select #(.NUM_VOICES(NUM_VOICES)) u_select (
    .state       (voice_state),
    .note        (voice_note),
    .rank        (rank),
    .key         (message.data_byte1),
    .match_valid (match_valid),
    .match_index (match_index),
    .held_valid  (held_valid),
    .held_index  (held_index),
    .idle_valid  (idle_valid),
    .idle_index  (idle_index),
    .steal_index (steal_index)
  );
  // decode the message and decide which voices start or release this cycle
  always_comb begin
    note_on  = message_ready && message.message_type == NOTE_ON && message.data_byte2 != 7'd0;
    note_off = message_ready && (message.message_type == NOTE_OFF ||
               (message.message_type == NOTE_ON && message.data_byte2 == 7'd0));
    all_off  = message_ready && message.message_type == CONTROL_CHANGE &&
               message.data_byte1 == ALL_NOTES_OFF;
    target   = match_valid ? match_index : idle_valid ? idle_index : steal_index;
    for (int i = 0; i < NUM_VOICES; i++) begin
      gate_on[i]  = note_on && target == RW'(i);
      gate_off[i] = voice_state[i] == HELD &&
                    (all_off || (note_off && held_valid && held_index == RW'(i)));
    end
  end
  // voice registers; an allocation overrides a same-cycle release_done
  always_ff @(posedge clock_50_000_000 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        voice_state[i]    <= IDLE;
        voice_note[i]     <= '0;
        voice_velocity[i] <= '0;
        rank[i]           <= RW'(i);
      end
      voice_gate_on  <= '0;
      voice_gate_off <= '0;
    end else begin
      voice_gate_on  <= gate_on;
      voice_gate_off <= gate_off;
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (gate_on[i]) begin
          voice_state[i]    <= HELD;
          voice_note[i]     <= message.data_byte1;
          voice_velocity[i] <= message.data_byte2;
          rank[i]           <= '0;
        end else begin
          if (gate_off[i]) voice_state[i] <= RELEASING;
          else if (release_done[i] && voice_state[i] == RELEASING) voice_state[i] <= IDLE;
          if (note_on && rank[i] < rank[target]) rank[i] <= rank[i] + RW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: vector table, corner sequences and random run against a queue-based model
module tb_voice_allocator;
  import MIDI::*, VOICE::*;
  localparam int NV = 4;
  logic           clk = 1'b0;
  logic           reset = 1'b1;
  message_t       message;
  logic           message_ready;
  logic [NV-1:0]  release_done;
  voice_state_t   voice_state [NV];
  logic [6:0]     voice_note [NV];
  logic [6:0]     voice_velocity [NV];
  logic [NV-1:0]  voice_gate_on, voice_gate_off;
  int             errors = 0, checks = 0;
  voice_state_t   m_state [NV];
  logic [6:0]     m_note [NV], m_vel [NV];
  logic [NV-1:0]  m_gon, m_goff;
  int             age_q [$];
  typedef struct {
    bit            rst;
    bit            rdy;
    message_type_t t;
    logic [6:0]    b1, b2;
    logic [NV-1:0] rd;
    int            v;
    voice_state_t  st;
    logic [6:0]    nt, vl;
    bit            gon, goff;
  } vec_t;
  vec_t vecs [$];

  voice_allocator #(.NUM_VOICES(NV)) dut (
    .clock_50_000_000 (clk),
    .reset            (reset),
    .message          (message),
    .message_ready    (message_ready),
    .release_done     (release_done),
    .voice_state      (voice_state),
    .voice_note       (voice_note),
    .voice_velocity   (voice_velocity),
    .voice_gate_on    (voice_gate_on),
    .voice_gate_off   (voice_gate_off)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(bit rst, bit rdy, message_type_t t, int b1, int b2, int rd,
                              int v, voice_state_t st, int nt, int vl, bit gon, bit goff);
    vec_t r;
    r.rst = rst; r.rdy = rdy; r.t = t; r.b1 = 7'(b1); r.b2 = 7'(b2); r.rd = NV'(rd);
    r.v = v; r.st = st; r.nt = 7'(nt); r.vl = 7'(vl); r.gon = gon; r.goff = goff;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int age_of(int v);
    foreach (age_q[p]) if (age_q[p] == v) return p;
    return -1;
  endfunction

  task automatic model_reset();
    age_q = {};
    for (int v = 0; v < NV; v++) begin
      m_state[v] = IDLE; m_note[v] = 0; m_vel[v] = 0;
      age_q.push_back(v);
    end
    m_gon = 0; m_goff = 0;
  endtask

  task automatic model_step(input message_t m, input logic rdy, input logic [NV-1:0] rd);
    int tgt, off;
    bit on, offm, all;
    on   = rdy && m.message_type == NOTE_ON && m.data_byte2 != 0;
    offm = rdy && (m.message_type == NOTE_OFF || (m.message_type == NOTE_ON && m.data_byte2 == 0));
    all  = rdy && m.message_type == CONTROL_CHANGE && m.data_byte1 == 123;
    tgt = -1; off = -1;
    for (int v = 0; v < NV; v++) if (tgt < 0 && m_state[v] != IDLE && m_note[v] == m.data_byte1) tgt = v;
    for (int v = 0; v < NV; v++) if (off < 0 && m_state[v] == HELD && m_note[v] == m.data_byte1) off = v;
    for (int v = 0; v < NV; v++) if (tgt < 0 && m_state[v] == IDLE) tgt = v;
    for (int p = NV - 1; p >= 0; p--) if (tgt < 0 && m_state[age_q[p]] == RELEASING) tgt = age_q[p];
    for (int p = NV - 1; p >= 0; p--) if (tgt < 0 && m_state[age_q[p]] == HELD) tgt = age_q[p];
    m_gon = 0; m_goff = 0;
    for (int v = 0; v < NV; v++) if (rd[v] && m_state[v] == RELEASING) m_state[v] = IDLE;
    if (offm && off >= 0) begin
      m_state[off] = RELEASING; m_goff[off] = 1'b1;
    end
    if (all) for (int v = 0; v < NV; v++) if (m_state[v] == HELD) begin
      m_state[v] = RELEASING; m_goff[v] = 1'b1;
    end
    if (on) begin
      m_state[tgt] = HELD; m_note[tgt] = m.data_byte1; m_vel[tgt] = m.data_byte2; m_gon[tgt] = 1'b1;
      age_q.delete(age_of(tgt));
      age_q.push_front(tgt);
    end
  endtask

  task automatic compare_all();
    for (int v = 0; v < NV; v++) begin
      check($sformatf("state[%0d]", v), int'(voice_state[v]), int'(m_state[v]));
      check($sformatf("note[%0d]", v), int'(voice_note[v]), int'(m_note[v]));
      check($sformatf("velocity[%0d]", v), int'(voice_velocity[v]), int'(m_vel[v]));
      check($sformatf("rank[%0d]", v), int'(dut.rank[v]), age_of(v));
    end
    check("gate_on", int'(voice_gate_on), int'(m_gon));
    check("gate_off", int'(voice_gate_off), int'(m_goff));
    check("gate_overlap", int'(voice_gate_on & voice_gate_off), 0);
  endtask

  task automatic cycle(input logic rdy, input message_type_t t, input logic [6:0] b1, input logic [6:0] b2,
                       input logic [NV-1:0] rd);
    message.message_type = t; message.data_byte1 = b1; message.data_byte2 = b2;
    message_ready = rdy; release_done = rd;
    @(posedge clk);
    model_step(message, rdy, rd);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    message_ready = 1'b0; release_done = '0; reset = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    compare_all();
  endtask

  initial begin
    vec_t r;
    message = '0; message_ready = 1'b0; release_done = '0;
    model_reset();
    vecs.push_back(mk(1, 0, NOTE_OFF, 0, 0, 0, 0, IDLE, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, NOTE_ON, 60, 100, 0, 0, HELD, 60, 100, 1, 0));
    vecs.push_back(mk(0, 1, NOTE_ON, 64, 90, 0, 1, HELD, 64, 90, 1, 0));
    vecs.push_back(mk(1, 0, NOTE_OFF, 0, 0, 0, 1, IDLE, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, NOTE_ON, 60, 10, 0, 0, HELD, 60, 10, 1, 0));
    vecs.push_back(mk(0, 1, NOTE_ON, 62, 11, 0, 1, HELD, 62, 11, 1, 0));
    vecs.push_back(mk(0, 1, NOTE_ON, 64, 12, 0, 2, HELD, 64, 12, 1, 0));
    vecs.push_back(mk(0, 1, NOTE_ON, 65, 13, 0, 3, HELD, 65, 13, 1, 0));
    vecs.push_back(mk(0, 1, NOTE_ON, 67, 80, 0, 0, HELD, 67, 80, 1, 0));
    vecs.push_back(mk(0, 1, NOTE_ON, 64, 99, 0, 2, HELD, 64, 99, 1, 0));
    vecs.push_back(mk(1, 0, NOTE_OFF, 0, 0, 0, 0, IDLE, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, NOTE_ON, 60, 10, 0, 0, HELD, 60, 10, 1, 0));
    vecs.push_back(mk(0, 1, NOTE_ON, 62, 11, 0, 1, HELD, 62, 11, 1, 0));
    vecs.push_back(mk(0, 1, NOTE_ON, 64, 12, 0, 2, HELD, 64, 12, 1, 0));
    vecs.push_back(mk(0, 1, NOTE_ON, 65, 13, 0, 3, HELD, 65, 13, 1, 0));
    vecs.push_back(mk(0, 1, NOTE_OFF, 62, 0, 0, 1, RELEASING, 62, 11, 0, 1));
    vecs.push_back(mk(0, 1, NOTE_ON, 67, 50, 0, 1, HELD, 67, 50, 1, 0));
    vecs.push_back(mk(0, 1, NOTE_OFF, 99, 0, 0, 1, HELD, 67, 50, 0, 0));
    vecs.push_back(mk(1, 0, NOTE_OFF, 0, 0, 0, 2, IDLE, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, NOTE_ON, 50, 10, 0, 0, HELD, 50, 10, 1, 0));
    vecs.push_back(mk(0, 1, NOTE_ON, 51, 11, 0, 1, HELD, 51, 11, 1, 0));
    vecs.push_back(mk(0, 1, NOTE_ON, 60, 12, 0, 2, HELD, 60, 12, 1, 0));
    vecs.push_back(mk(0, 1, NOTE_ON, 60, 0, 0, 2, RELEASING, 60, 12, 0, 1));
    vecs.push_back(mk(0, 0, NOTE_OFF, 0, 0, 4, 2, IDLE, 60, 12, 0, 0));
    vecs.push_back(mk(0, 1, NOTE_ON, 70, 20, 0, 2, HELD, 70, 20, 1, 0));
    vecs.push_back(mk(1, 0, NOTE_OFF, 0, 0, 0, 1, IDLE, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, NOTE_ON, 60, 10, 0, 0, HELD, 60, 10, 1, 0));
    vecs.push_back(mk(0, 1, NOTE_ON, 62, 11, 0, 1, HELD, 62, 11, 1, 0));
    vecs.push_back(mk(0, 1, NOTE_ON, 64, 12, 0, 2, HELD, 64, 12, 1, 0));
    vecs.push_back(mk(0, 1, NOTE_ON, 65, 13, 0, 3, HELD, 65, 13, 1, 0));
    vecs.push_back(mk(0, 1, NOTE_OFF, 62, 0, 0, 1, RELEASING, 62, 11, 0, 1));
    vecs.push_back(mk(0, 1, NOTE_ON, 70, 33, 2, 1, HELD, 70, 33, 1, 0));
    vecs.push_back(mk(1, 0, NOTE_OFF, 0, 0, 0, 0, IDLE, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, NOTE_ON, 60, 10, 0, 0, HELD, 60, 10, 1, 0));
    vecs.push_back(mk(0, 1, NOTE_ON, 61, 11, 0, 1, HELD, 61, 11, 1, 0));
    vecs.push_back(mk(0, 1, NOTE_ON, 62, 12, 0, 2, HELD, 62, 12, 1, 0));
    vecs.push_back(mk(0, 1, CONTROL_CHANGE, 123, 0, 0, 0, RELEASING, 60, 10, 0, 1));
    vecs.push_back(mk(0, 1, CONTROL_CHANGE, 7, 0, 0, 0, RELEASING, 60, 10, 0, 0));
    vecs.push_back(mk(0, 1, PITCH_BEND, 60, 0, 0, 0, RELEASING, 60, 10, 0, 0));
    vecs.push_back(mk(0, 0, NOTE_OFF, 0, 0, 1, 0, IDLE, 60, 10, 0, 0));
    foreach (vecs[i]) begin
      r = vecs[i];
      if (r.rst) do_reset();
      else cycle(r.rdy, r.t, r.b1, r.b2, r.rd);
      reset = 1'b0;
      check($sformatf("vec%0d state", i), int'(voice_state[r.v]), int'(r.st));
      check($sformatf("vec%0d note", i), int'(voice_note[r.v]), int'(r.nt));
      check($sformatf("vec%0d velocity", i), int'(voice_velocity[r.v]), int'(r.vl));
      check($sformatf("vec%0d gate_on", i), int'(voice_gate_on[r.v]), int'(r.gon));
      check($sformatf("vec%0d gate_off", i), int'(voice_gate_off[r.v]), int'(r.goff));
    end
    check("cc123 gate_off count", $countones(voice_gate_off), 0);
    cycle(1, NOTE_ON, 63, 40, 0);
    cycle(1, NOTE_ON, 66, 41, 0);
    message.message_type = NOTE_ON; message.data_byte1 = 7'd70; message.data_byte2 = 7'd50;
    message_ready = 1'b1; release_done = '0;
    #3 reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1 reset = 1'b0;
    message_ready = 1'b0;
    compare_all();
    cycle(0, NOTE_OFF, 0, 0, 0);
    check("no pulse after reset", int'(voice_gate_on | voice_gate_off), 0);
    for (int n = 0; n < 600; n++) begin
      message_type_t t;
      int sel;
      logic [6:0] b1, b2;
      sel = $urandom_range(0, 9);
      t = sel < 5 ? NOTE_ON : sel < 7 ? NOTE_OFF : sel == 7 ? CONTROL_CHANGE : sel == 8 ? PITCH_BEND : PROGRAM_CHANGE;
      b1 = (t == CONTROL_CHANGE && $urandom_range(0, 1) == 1) ? 7'd123 : 7'($urandom_range(60, 67));
      b2 = $urandom_range(0, 3) == 0 ? 7'd0 : 7'($urandom_range(1, 127));
      cycle($urandom_range(0, 9) < 7, t, b1, b2, NV'($urandom) & NV'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
